// File: rtl/alu_arbiter_if.sv
// Requester-side bundle for the ALU arbiter: two request/response port pairs.
// The arbiter takes the slave view; each requester takes the master view.
interface alu_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [OPW-1:0]  req0_op;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_result;
  logic            rsp0_zero;

  logic            req1_valid;
  logic            req1_ready;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_result;
  logic            rsp1_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a one-entry registered response buffer and a saturating grant counter per port.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic [OPW-1:0]   alu_op,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_zero,
  output logic [CNTW-1:0]  gnt_cnt0,
  output logic [CNTW-1:0]  gnt_cnt1
);

  logic            elig0_s;
  logic            elig1_s;
  logic            grant0_s;
  logic            grant1_s;
  logic            last_grant_r;
  logic            rsp0_valid_r;
  logic            rsp1_valid_r;
  logic [XLEN-1:0] rsp0_result_r;
  logic [XLEN-1:0] rsp1_result_r;
  logic            rsp0_zero_r;
  logic            rsp1_zero_r;
  logic [CNTW-1:0] gnt_cnt0_r;
  logic [CNTW-1:0] gnt_cnt1_r;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == {CNTW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNTW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Eligibility and round-robin grant; a buffer drained this cycle may be refilled
  always_comb begin
    elig0_s  = bus.req0_valid & (~rsp0_valid_r | bus.rsp0_ready);
    elig1_s  = bus.req1_valid & (~rsp1_valid_r | bus.rsp1_ready);
    grant0_s = elig0_s & (~elig1_s | last_grant_r);
    grant1_s = elig1_s & (~elig0_s | ~last_grant_r);
  end

  // ALU operand mux, forced to zero when nobody is granted
  always_comb begin
    alu_op = {OPW{1'b0}};
    alu_a  = {XLEN{1'b0}};
    alu_b  = {XLEN{1'b0}};
    case ({grant1_s, grant0_s})
      2'b01: begin
        alu_op = bus.req0_op;
        alu_a  = bus.req0_a;
        alu_b  = bus.req0_b;
      end
      2'b10: begin
        alu_op = bus.req1_op;
        alu_a  = bus.req1_a;
        alu_b  = bus.req1_b;
      end
      default: begin
        alu_op = {OPW{1'b0}};
        alu_a  = {XLEN{1'b0}};
        alu_b  = {XLEN{1'b0}};
      end
    endcase
  end

  // Response buffers, round-robin pointer and grant counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid_r  <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rsp0_result_r <= {XLEN{1'b0}};
      rsp1_result_r <= {XLEN{1'b0}};
      rsp0_zero_r   <= 1'b0;
      rsp1_zero_r   <= 1'b0;
      last_grant_r  <= 1'b1;
      gnt_cnt0_r    <= {CNTW{1'b0}};
      gnt_cnt1_r    <= {CNTW{1'b0}};
    end else begin
      if (grant0_s) begin
        rsp0_valid_r  <= 1'b1;
        rsp0_result_r <= alu_result;
        rsp0_zero_r   <= alu_zero;
        gnt_cnt0_r    <= sat_inc(gnt_cnt0_r);
      end else if (bus.rsp0_ready) begin
        rsp0_valid_r  <= 1'b0;
      end

      if (grant1_s) begin
        rsp1_valid_r  <= 1'b1;
        rsp1_result_r <= alu_result;
        rsp1_zero_r   <= alu_zero;
        gnt_cnt1_r    <= sat_inc(gnt_cnt1_r);
      end else if (bus.rsp1_ready) begin
        rsp1_valid_r  <= 1'b0;
      end

      // Idle cycles leave the pointer where it is
      if (grant0_s) begin
        last_grant_r <= 1'b0;
      end else if (grant1_s) begin
        last_grant_r <= 1'b1;
      end
    end
  end

  assign bus.req0_ready  = grant0_s;
  assign bus.req1_ready  = grant1_s;
  assign bus.rsp0_valid  = rsp0_valid_r;
  assign bus.rsp1_valid  = rsp1_valid_r;
  assign bus.rsp0_result = rsp0_result_r;
  assign bus.rsp1_result = rsp1_result_r;
  assign bus.rsp0_zero   = rsp0_zero_r;
  assign bus.rsp1_zero   = rsp1_zero_r;
  assign gnt_cnt0        = gnt_cnt0_r;
  assign gnt_cnt1        = gnt_cnt1_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: small ALU model, per-port scoreboards of expected
// responses, and explicit grant expectations for each cycle.
module tb_alu_arbiter;
  localparam int XLEN = 32;
  localparam int OPW  = 4;
  localparam int CNTW = 3;
  localparam logic [OPW-1:0] OP_ADD = 4'b0010;
  localparam logic [OPW-1:0] OP_SUB = 4'b0110;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic [CNTW-1:0] gnt_cnt0;
  logic [CNTW-1:0] gnt_cnt1;

  int checks   = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [CNTW-1:0] cnt0_m;
  logic [CNTW-1:0] cnt1_m;
  logic rv0_m;
  logic rv1_m;

  alu_arbiter_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

  alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  function automatic exp_t ref_alu(input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    exp_t e;
    case (op)
      OP_ADD:  e.result = a + b;
      OP_SUB:  e.result = a - b;
      default: e.result = a ^ b;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_op, alu_a, alu_b).result;
    alu_zero   = ref_alu(alu_op, alu_a, alu_b).zero;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check grants and ALU drive mid-cycle, then score the registered responses.
  task automatic cycle(input logic exp_g0, input logic exp_g1);
    logic g0, g1, rdy0, rdy1;
    exp_t e;
    @(negedge clk);
    g0 = bus.req0_ready;
    g1 = bus.req1_ready;
    rdy0 = bus.rsp0_ready;
    rdy1 = bus.rsp1_ready;
    check("req0_ready", {63'd0, g0}, {63'd0, exp_g0});
    check("req1_ready", {63'd0, g1}, {63'd0, exp_g1});
    if (exp_g0) begin
      check("alu_drive0", {28'd0, alu_op, alu_a}, {28'd0, bus.req0_op, bus.req0_a});
      check("alu_b0", {32'd0, alu_b}, {32'd0, bus.req0_b});
    end else if (exp_g1) begin
      check("alu_drive1", {28'd0, alu_op, alu_a}, {28'd0, bus.req1_op, bus.req1_a});
      check("alu_b1", {32'd0, alu_b}, {32'd0, bus.req1_b});
    end else begin
      check("alu_idle", {28'd0, alu_op, alu_a}, 64'd0);
      check("alu_idle_b", {32'd0, alu_b}, 64'd0);
    end
    if (rst_n) begin
      if (g0) begin
        q0.push_back(ref_alu(bus.req0_op, bus.req0_a, bus.req0_b));
        if (cnt0_m != 3'b111) cnt0_m = cnt0_m + 3'd1;
      end
      if (g1) begin
        q1.push_back(ref_alu(bus.req1_op, bus.req1_a, bus.req1_b));
        if (cnt1_m != 3'b111) cnt1_m = cnt1_m + 3'd1;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      cnt0_m = 3'd0;
      cnt1_m = 3'd0;
      rv0_m  = 1'b0;
      rv1_m  = 1'b0;
    end else begin
      if (g0) rv0_m = 1'b1; else if (rdy0) rv0_m = 1'b0;
      if (g1) rv1_m = 1'b1; else if (rdy1) rv1_m = 1'b0;
      if (g0 && q0.size() > 0) begin
        e = q0.pop_front();
        check("rsp0_data", {31'd0, bus.rsp0_result, bus.rsp0_zero}, {31'd0, e.result, e.zero});
      end
      if (g1 && q1.size() > 0) begin
        e = q1.pop_front();
        check("rsp1_data", {31'd0, bus.rsp1_result, bus.rsp1_zero}, {31'd0, e.result, e.zero});
      end
    end
    check("rsp0_valid", {63'd0, bus.rsp0_valid}, {63'd0, rv0_m});
    check("rsp1_valid", {63'd0, bus.rsp1_valid}, {63'd0, rv1_m});
    check("gnt_cnt0", {61'd0, gnt_cnt0}, {61'd0, cnt0_m});
    check("gnt_cnt1", {61'd0, gnt_cnt1}, {61'd0, cnt1_m});
  endtask

  initial begin
    cnt0_m = 3'd0; cnt1_m = 3'd0; rv0_m = 1'b0; rv1_m = 1'b0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("reset_rsp", {30'd0, bus.rsp0_result, bus.rsp0_zero, bus.rsp1_zero}, 64'd0);
    check("reset_rsp1", {32'd0, bus.rsp1_result}, 64'd0);

    // Single add 5+7 on port 0
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    cycle(1'b1, 1'b0);
    bus.req0_valid = 1'b0;
    check("add_result", {32'd0, bus.rsp0_result}, 64'd12);
    check("add_cnt0", {61'd0, gnt_cnt0}, 64'd1);
    cycle(1'b0, 1'b0);

    // Conflict right after reset: port 0 first, then port 1
    rst_n = 1'b0;
    cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd7; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = 32'd3; bus.req1_b = 32'd3;
    cycle(1'b1, 1'b0);
    check("conflict_rsp0", {32'd0, bus.rsp0_result}, 64'd8);
    bus.req0_valid = 1'b0;
    cycle(1'b0, 1'b1);
    check("conflict_rsp1", {32'd0, bus.rsp1_result}, 64'd6);
    bus.req1_valid = 1'b0;

    // Both streaming: strict alternation from a fresh reset
    rst_n = 1'b0;
    cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(i % 2 == 0, i % 2 == 1);
      if (i % 2 == 0) bus.req0_a = bus.req0_a + 32'd1;
      else            bus.req1_a = bus.req1_a + 32'd2;
    end
    check("stream_cnts", {58'd0, gnt_cnt0, gnt_cnt1}, {58'd0, 3'd3, 3'd3});

    // Backpressure on port 0 while port 1 keeps streaming
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b0;
    bus.req0_op = OP_ADD; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    cycle(1'b1, 1'b0);
    bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1);
      check("bp_hold", {32'd0, bus.rsp0_result}, 64'd12);
      bus.req1_a = bus.req1_a + 32'd1;
    end
    bus.rsp0_ready = 1'b1;
    cycle(1'b1, 1'b0);
    check("drain_refill", {32'd0, bus.rsp0_result}, 64'd2);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

    // Subtract 9-9 on port 1 gives a zero flag, then ALU drive returns to zero
    bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = 32'd9; bus.req1_b = 32'd9;
    cycle(1'b0, 1'b1);
    bus.req1_valid = 1'b0;
    check("sub_zero", {31'd0, bus.rsp1_result, bus.rsp1_zero}, 64'd1);
    cycle(1'b0, 1'b0);

    // Saturating counter on port 0
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = 32'd0; bus.req0_b = 32'd1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      bus.req0_a = bus.req0_a + 32'd3;
    end
    check("cnt0_sat", {61'd0, gnt_cnt0}, 64'd7);

    // Reset in the same cycle as a port 0 grant drops it
    rst_n = 1'b0;
    bus.req0_a = 32'd2; bus.req0_b = 32'd2;
    cycle(1'b1, 1'b0);
    check("rst_drop", {60'd0, bus.rsp0_valid, gnt_cnt0}, 64'd0);
    rst_n = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_op = OP_ADD; bus.req1_a = 32'd4; bus.req1_b = 32'd4;
    cycle(1'b1, 1'b0);
    check("post_rst_rsp0", {32'd0, bus.rsp0_result}, 64'd4);
    bus.req0_valid = 1'b0;
    cycle(1'b0, 1'b1);
    check("post_rst_rsp1", {32'd0, bus.rsp1_result}, 64'd8);
    bus.req1_valid = 1'b0;
    cycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
